// File: rtl/pillar_mem_pkg.sv
// Shared types and default sizing for the fetch/LSU RAM arbiter.
// Holds the FSM state enum, the requester port-id enum and the default
// ADDR_W / DATA_W / ADDR_LIMIT constants used by the interface and the top.
package pillar_mem_pkg;

    localparam int unsigned DEF_ADDR_W     = 32;
    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_ADDR_LIMIT = 65536;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_id_e;

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the core requesters, the arbiter and the word RAM.
// Fetch port  : if_req_valid/if_req_ready/if_addr, if_rsp_valid/if_rsp_ready/
//               if_rsp_rdata/if_rsp_err.
// Data port   : d_req_valid/d_req_ready/d_we/d_addr/d_wdata, d_rsp_valid/
//               d_rsp_ready/d_rsp_rdata/d_rsp_err.
// RAM side    : ram_we/ram_addr/ram_wdata out of the arbiter, ram_rdata
//               (combinational read data) into it.
// Modports    : slave = arbiter view, master = requester/RAM view.
interface ram_arbiter_if
    import pillar_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
);
    logic              if_req_valid;
    logic              if_req_ready;
    logic [ADDR_W-1:0] if_addr;
    logic              if_rsp_valid;
    logic              if_rsp_ready;
    logic [DATA_W-1:0] if_rsp_rdata;
    logic              if_rsp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_rsp_valid;
    logic              d_rsp_ready;
    logic [DATA_W-1:0] d_rsp_rdata;
    logic              d_rsp_err;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  if_req_valid, if_addr, if_rsp_ready,
        input  d_req_valid, d_we, d_addr, d_wdata, d_rsp_ready,
        input  ram_rdata,
        output if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        output ram_we, ram_addr, ram_wdata
    );

    modport master (
        output if_req_valid, if_addr, if_rsp_ready,
        output d_req_valid, d_we, d_addr, d_wdata, d_rsp_ready,
        output ram_rdata,
        input  if_req_ready, if_rsp_valid, if_rsp_rdata, if_rsp_err,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err,
        input  ram_we, ram_addr, ram_wdata
    );

endinterface

// File: rtl/ram_arb_grant.sv
// Combinational grant between the fetch and data requesters.
// Inputs : if_valid, d_valid, and last_grant (only when RAM_ARBITER_RR_EN).
// Outputs: grant_valid (any requester active), grant (winning port id).
// Macro RAM_ARBITER_RR_EN: round-robin on ties (the port not granted last
// wins); otherwise fixed priority with data over fetch.
module ram_arb_grant
    import pillar_mem_pkg::*;
(
    input  logic     if_valid,
    input  logic     d_valid,
`ifdef RAM_ARBITER_RR_EN
    input  port_id_e last_grant,
`endif
    output logic     grant_valid,
    output port_id_e grant
);

    always_comb begin
        grant_valid = if_valid | d_valid;
        grant       = PORT_D;
`ifdef RAM_ARBITER_RR_EN
        if (if_valid && d_valid) begin
            grant = (last_grant == PORT_D) ? PORT_IF : PORT_D;
        end else if (if_valid) begin
            grant = PORT_IF;
        end
`else
        if (if_valid && !d_valid) begin
            grant = PORT_IF;
        end
`endif
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port controller sharing one single-port word RAM between instruction
// fetch and load/store. One access per transaction: IDLE (grant + latch
// request), ACCESS (drive RAM, register read data), RESP (hold response until
// the owning port's rsp_ready).
// Ports: clk, reset (async, active-high), bus (ram_arbiter_if.slave).
// Macro RAM_ARBITER_RR_EN enables round-robin arbitration with a last_grant
// register; default build is fixed priority, data over fetch.
module ram_arbiter
    import pillar_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned ADDR_LIMIT = DEF_ADDR_LIMIT
)(
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);

    state_e            state_q, state_d;
    port_id_e          port_q, port_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef RAM_ARBITER_RR_EN
    port_id_e          last_grant_q, last_grant_d;
`endif

    logic              grant_valid;
    port_id_e          grant;
    logic [ADDR_W-1:0] sel_addr;
    logic              rsp_ready_sel;

    ram_arb_grant u_grant (
        .if_valid    (bus.if_req_valid),
        .d_valid     (bus.d_req_valid),
`ifdef RAM_ARBITER_RR_EN
        .last_grant  (last_grant_q),
`endif
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            port_q  <= PORT_IF;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef RAM_ARBITER_RR_EN
            last_grant_q <= PORT_IF;
`endif
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef RAM_ARBITER_RR_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    // Next-state and request latching
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef RAM_ARBITER_RR_EN
        last_grant_d = last_grant_q;
`endif
        sel_addr      = (grant == PORT_D) ? bus.d_addr : bus.if_addr;
        rsp_ready_sel = (port_q == PORT_D) ? bus.d_rsp_ready : bus.if_rsp_ready;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    port_d  = grant;
                    addr_d  = sel_addr;
                    we_d    = (grant == PORT_D) && bus.d_we;
                    wdata_d = (grant == PORT_D) ? bus.d_wdata : '0;
                    err_d   = (sel_addr >= ADDR_W'(ADDR_LIMIT));
`ifdef RAM_ARBITER_RR_EN
                    last_grant_d = grant;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                // Stores and out-of-range accesses return zero data
                rdata_d = (!we_q && !err_q) ? bus.ram_rdata : '0;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_sel) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.if_req_ready = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.if_rsp_valid = 1'b0;
        bus.if_rsp_rdata = '0;
        bus.if_rsp_err   = 1'b0;
        bus.d_rsp_valid  = 1'b0;
        bus.d_rsp_rdata  = '0;
        bus.d_rsp_err    = 1'b0;
        bus.ram_we       = 1'b0;
        bus.ram_addr     = '0;
        bus.ram_wdata    = '0;

        unique case (state_q)
            IDLE: begin
                // Gated by reset so no ready is offered while reset is held
                if (grant_valid && !reset) begin
                    bus.d_req_ready  = (grant == PORT_D);
                    bus.if_req_ready = (grant == PORT_IF);
                end
            end
            ACCESS: begin
                bus.ram_addr  = addr_q;
                bus.ram_wdata = wdata_q;
                bus.ram_we    = we_q & ~err_q;
            end
            RESP: begin
                if (port_q == PORT_D) begin
                    bus.d_rsp_valid = 1'b1;
                    bus.d_rsp_rdata = rdata_q;
                    bus.d_rsp_err   = err_q;
                end else begin
                    bus.if_rsp_valid = 1'b1;
                    bus.if_rsp_rdata = rdata_q;
                    bus.if_rsp_err   = err_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed stimulus pushes expected
// responses into a queue, a monitor pops and compares on each response
// handshake. Honours RAM_ARBITER_RR_EN for the expected grant order.
module tb_ram_arbiter;
    import pillar_mem_pkg::*;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   we_cnt = 0;
    exp_t exp_q[$];

    logic [31:0] mem [0:255] = '{default: '0};

    ram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .ADDR_LIMIT(65536)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, write on the clock edge
    assign bus.ram_rdata = mem[bus.ram_addr[7:0]];
    always @(posedge clk) begin
        if (bus.ram_we) begin
            mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            we_cnt <= we_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        e.is_d = is_d; e.rdata = rdata; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic is_d, input logic [31:0] rdata, input logic err);
        exp_t e;
        if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_rsp: got port %0d with no response expected", is_d);
        end else begin
            e = exp_q.pop_front();
            check("rsp_port", {31'b0, is_d}, {31'b0, e.is_d});
            check("rsp_rdata", rdata, e.rdata);
            check("rsp_err", {31'b0, err}, {31'b0, e.err});
        end
    endtask

    // Monitor: compare each response handshake against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus.if_rsp_valid && bus.d_rsp_valid)
                    check("both_rsp_valid", 32'd1, 32'd0);
                if (bus.if_rsp_valid && bus.if_rsp_ready)
                    pop_cmp(1'b0, bus.if_rsp_rdata, bus.if_rsp_err);
                if (bus.d_rsp_valid && bus.d_rsp_ready)
                    pop_cmp(1'b1, bus.d_rsp_rdata, bus.d_rsp_err);
            end
        end
    end

    task automatic send(input logic is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output int waited);
        logic rdy;
        if (is_d) begin
            bus.d_req_valid = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req_valid = 1'b1; bus.if_addr = addr;
        end
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
            rdy = is_d ? bus.d_req_ready : bus.if_req_ready;
        end while (!rdy && waited < 30);
        check(is_d ? "d_req_handshake" : "if_req_handshake", {31'b0, rdy}, 32'd1);
        @(posedge clk); #1;
        if (is_d) begin
            bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        end else begin
            bus.if_req_valid = 1'b0; bus.if_addr = '0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int we0;
        logic exp_grant [4];
`ifdef RAM_ARBITER_RR_EN
        exp_grant = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_grant = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        bus.if_req_valid = 1'b0; bus.if_addr = '0; bus.if_rsp_ready = 1'b1;
        bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.d_rsp_ready = 1'b1;

        // Reset: outputs must be 0 even with requests pending
        bus.d_req_valid = 1'b1; bus.if_req_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_d_req_ready", {31'b0, bus.d_req_ready}, 32'd0);
        check("rst_if_req_ready", {31'b0, bus.if_req_ready}, 32'd0);
        check("rst_rsp_valid", {30'b0, bus.d_rsp_valid, bus.if_rsp_valid}, 32'd0);
        check("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
        check("rst_ram_addr", bus.ram_addr, 32'd0);
        check("rst_ram_wdata", bus.ram_wdata, 32'd0);
        bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // Store 0x10 <- DEADBEEF with cycle-exact checks
        push_exp(1'b1, 32'h0, 1'b0);
        send(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, n);
        check("st_ready_cycle0", n, 32'd1);
        @(negedge clk);
        check("st_ram_we_c1", {31'b0, bus.ram_we}, 32'd1);
        check("st_ram_addr_c1", bus.ram_addr, 32'h10);
        check("st_ram_wdata_c1", bus.ram_wdata, 32'hDEADBEEF);
        check("st_no_rsp_c1", {31'b0, bus.d_rsp_valid}, 32'd0);
        @(negedge clk);
        check("st_rsp_valid_c2", {31'b0, bus.d_rsp_valid}, 32'd1);
        check("st_ram_we_c2", {31'b0, bus.ram_we}, 32'd0);
        drain();
        check("st_mem", mem[8'h10], 32'hDEADBEEF);

        // Fetch load 0x10
        push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        send(1'b0, 1'b0, 32'h10, 32'h0, n);
        @(negedge clk);
        check("ld_no_rsp_c1", {31'b0, bus.if_rsp_valid}, 32'd0);
        @(negedge clk);
        check("ld_rsp_valid_c2", {31'b0, bus.if_rsp_valid}, 32'd1);
        check("ld_rdata_c2", bus.if_rsp_rdata, 32'hDEADBEEF);
        drain();

        // Contention: both valid for 4 transactions
        for (int k = 0; k < 4; k++)
            push_exp(exp_grant[k], exp_grant[k] ? 32'hDEADBEEF : 32'h0, 1'b0);
        bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(bus.d_req_ready || bus.if_req_ready) && n < 30);
            check("tie_grant", {30'b0, bus.d_req_ready, bus.if_req_ready},
                  exp_grant[k] ? 32'd2 : 32'd1);
            check("tie_spacing", n, (k == 0) ? 32'd1 : 32'd3);
            @(posedge clk); #1;
        end
        bus.d_req_valid = 1'b0; bus.if_req_valid = 1'b0;
        drain();

        // Out-of-range store/load
        push_exp(1'b1, 32'h0, 1'b0);
        send(1'b1, 1'b1, 32'h0, 32'hCAFEF00D, n);
        drain();
        we0 = we_cnt;
        push_exp(1'b1, 32'h0, 1'b1);
        send(1'b1, 1'b1, 32'd65536, 32'h12345678, n);
        @(negedge clk);
        check("oor_ram_we", {31'b0, bus.ram_we}, 32'd0);
        drain();
        check("oor_no_write", we_cnt, we0);
        check("oor_mem0", mem[0], 32'hCAFEF00D);
        push_exp(1'b1, 32'h0, 1'b1);
        send(1'b1, 1'b0, 32'd65536, 32'h0, n);
        drain();

        // Backpressure on data response, with a fetch waiting
        bus.d_rsp_ready = 1'b0;
        push_exp(1'b1, 32'hCAFEF00D, 1'b0);
        push_exp(1'b0, 32'hDEADBEEF, 1'b0);
        send(1'b1, 1'b0, 32'h0, 32'h0, n);
        bus.if_req_valid = 1'b1; bus.if_addr = 32'h10;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp_valid", {31'b0, bus.d_rsp_valid}, 32'd1);
            check("bp_rsp_rdata", bus.d_rsp_rdata, 32'hCAFEF00D);
            check("bp_req_ready", {30'b0, bus.d_req_ready, bus.if_req_ready}, 32'd0);
        end
        @(posedge clk); #1 bus.d_rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_complete", {31'b0, bus.d_rsp_valid}, 32'd0);
        check("bp_if_ready", {31'b0, bus.if_req_ready}, 32'd1);
        @(posedge clk); #1;
        bus.if_req_valid = 1'b0; bus.if_addr = '0;
        drain();

        // Reset during ACCESS of a store
        push_exp(1'b1, 32'h0, 1'b0);
        send(1'b1, 1'b1, 32'h20, 32'h11111111, n);
        drain();
        we0 = we_cnt;
        send(1'b1, 1'b1, 32'h20, 32'h22222222, n);
        #2;
        check("rst_mid_we_before", {31'b0, bus.ram_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_we_drop", {31'b0, bus.ram_we}, 32'd0);
        check("rst_mid_state", {30'b0, dut.state_q}, {30'b0, IDLE});
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_mid_no_rsp", {30'b0, bus.d_rsp_valid, bus.if_rsp_valid}, 32'd0);
        end
        check("rst_mid_mem", mem[8'h20], 32'h11111111);
        check("rst_mid_no_write", we_cnt, we0);
        check("rst_mid_idle", {30'b0, dut.state_q}, {30'b0, IDLE});
        check("final_queue", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
